present_enc_arbiter: RTL and testbench
======================================

Name: present_enc_arbiter

Overview:
- Shares one PresentEnc core (80-bit key, 64-bit block) between two requesters, A and B.
- Arbitrates round-robin and latches the winner's key and plaintext.
- Drives the core's key/data write strobes, waits for the core's busy flag to clear, then returns the ciphertext to the requester that owns the job.
- Also watches each job with a timeout, so a stuck core cannot hang either requester.

Parameters:
- TIMEOUT, 64: maximum number of WAIT cycles per job before the job is aborted.
- TW, 7: width of the timeout counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- inClk  in  1  system clock; all logic on the rising edge.
- inRstN  in  1  asynchronous reset, active-low.
- inReqA  in  1  requester A job request (level).
- inKeyA  in  80  requester A key; must be stable while inReqA=1.
- inDataA  in  64  requester A plaintext; must be stable while inReqA=1.
- outAckA  out  1  one-cycle pulse: A's job has been latched.
- outValidA  out  1  one-cycle pulse: outDataA holds a new ciphertext.
- outDataA  out  64  A's last ciphertext; held until A's next result.
- inReqB, inKeyB, inDataB, outAckB, outValidB, outDataB: same as the A ports, for requester B.
- outEncKeyWr  out  1  key write strobe to the core.
- outEncKeyData  out  80  key to the core.
- outEncDataWr  out  1  plaintext write strobe to the core.
- outEncData  out  64  plaintext to the core.
- inEncData  in  64  ciphertext from the core.
- inEncBusy  in  1  core busy flag.
- outBusy  out  1  1 whenever the FSM is not in IDLE.
- outErr  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (inRstN=0, asynchronous):
  - FSM goes to IDLE.
  - All outputs are 0, including outDataA and outDataB.
  - The last-granted pointer is set to B, so A wins the first tie.
  - The timer is 0 and the job latches are 0.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - If only one request is high, that requester wins.
  - If both are high, the requester other than the last-granted one wins.
  - On a win: latch the winner's key, data and id; go to ISSUE.
  - If no request is high, stay in IDLE.
- ISSUE (exactly one cycle):
  - outEncKeyWr=1 and outEncDataWr=1, with outEncKeyData/outEncData driven from the latches.
  - outAck of the winner is 1 in this cycle.
  - Timer clears to 0; go to WAIT.
  - A requester must drop its request, or present a new job, in the cycle after its ack.
- WAIT:
  - Timer increments every cycle.
  - The busy flag is ignored in the first WAIT cycle (timer=0), because the core raises busy one cycle after the write.
  - Done condition: timer≥1 and inEncBusy=0.
    - Capture inEncData into the owner's outData register.
    - Pulse the owner's outValid in the next cycle (registered), which is the first IDLE cycle.
    - Update last-granted to the owner; go to IDLE.
  - Timeout: if timer reaches TIMEOUT before the done condition:
    - Set outErr=1.
    - No outValid is generated; outData is unchanged.
    - Last-granted is updated to the owner, so the other requester is not starved; go to IDLE.
- Strobes and data bus:
  - Strobes are 0 in every state except ISSUE.
  - outEncKeyData/outEncData hold the latched values between strobes; they are not cleared.
- Back-to-back jobs: the IDLE cycle that carries outValid may already select the next job.
  - The minimum issue-to-issue spacing is 3 cycles plus the core latency.
- Requests arriving during ISSUE or WAIT are held off (no ack). They are arbitrated on the next IDLE cycle.
- outBusy is 1 in ISSUE and WAIT, 0 in IDLE.
- Reset mid-job:
  - Outputs and FSM clear immediately.
  - The in-flight result is discarded.
  - No ack or valid is produced after reset deassertion until a new request arrives.

Test Plan:
- Reset, then inReqA=1 with inKeyA=0 and inDataA=0, real core:
  - outAckA pulses one cycle after the request is seen.
  - outValidA pulses once, with outDataA=64'h5579C1387B228445.
  - outValidB never pulses; outErr stays 0.
- inReqB with inKeyB=80'hFFFF_FFFF_FFFF_FFFF_FFFF and inDataB=0:
  - outDataB=64'hE72C46C0F5945049.
  - outDataA keeps its previous value.
- After reset, raise inReqA and inReqB on the same edge and hold both until acked:
  - Order is ackA, validA, ackB, validB.
  - Both ciphertexts are correct.
  - A third simultaneous request pair is granted B-first only if A was served last; check the alternation over 4 jobs.
- Core model holds inEncBusy=1 forever:
  - outErr rises exactly TIMEOUT WAIT cycles after the ISSUE cycle.
  - No outValid; FSM returns to IDLE.
  - A following job on a healthy core completes with outErr still 1.
- Assert inRstN=0 in the middle of WAIT:
  - All outputs are 0 in the same cycle.
  - After release, no spurious valid appears.
  - A fresh job on A completes normally.
- Check that outEncKeyWr and outEncDataWr are each high for exactly 1 cycle per job across 10 chained jobs.
  - In each job, the key is the previous key XOR the job index and the plaintext is the previous ciphertext.

Source files
------------

// File: rtl/present_enc_arbiter.sv
// present_enc_arbiter
//   Shares one PRESENT-80 encryption core between two requesters (A and B).
//   Round-robin arbitration in IDLE, one-cycle key/data write strobes to the
//   core in ISSUE, then WAIT polls the core busy flag until the ciphertext is
//   ready or the job times out.
//
// State table:
//   ST_IDLE  | no job in flight; arbitrate and latch the winner's key/data
//   ST_ISSUE | pulse key/data write strobes and the winner's ack
//   ST_WAIT  | count cycles, capture ciphertext on busy low or abort on timeout
//
// Ports:
//   inClk, inRstN            clock, async active-low reset
//   inReqA/inKeyA/inDataA    requester A job (level request, stable until ack)
//   outAckA/outValidA        A: job latched pulse / new ciphertext pulse
//   outDataA                 A: last ciphertext, held until A's next result
//   inReqB ... outDataB      same for requester B
//   outEncKeyWr/KeyData      key write strobe and key bus to the core
//   outEncDataWr/Data        plaintext write strobe and data bus to the core
//   inEncData/inEncBusy      ciphertext and busy flag from the core
//   outBusy                  high whenever a job is in flight
//   outErr                   sticky timeout flag, cleared only by reset
module present_enc_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        inClk,
  input  logic        inRstN,
  input  logic        inReqA,
  input  logic [79:0] inKeyA,
  input  logic [63:0] inDataA,
  output logic        outAckA,
  output logic        outValidA,
  output logic [63:0] outDataA,
  input  logic        inReqB,
  input  logic [79:0] inKeyB,
  input  logic [63:0] inDataB,
  output logic        outAckB,
  output logic        outValidB,
  output logic [63:0] outDataB,
  output logic        outEncKeyWr,
  output logic [79:0] outEncKeyData,
  output logic        outEncDataWr,
  output logic [63:0] outEncData,
  input  logic [63:0] inEncData,
  input  logic        inEncBusy,
  output logic        outBusy,
  output logic        outErr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  state_t        state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic          last_b_q,  last_b_d;   // 1: B was granted last
  logic          owner_b_q, owner_b_d;  // 1: job in flight belongs to B
  logic [79:0]   key_q,     key_d;
  logic [63:0]   data_q,    data_d;
  logic          ack_a_q,   ack_a_d;
  logic          ack_b_q,   ack_b_d;
  logic          valid_a_q, valid_a_d;
  logic          valid_b_q, valid_b_d;
  logic [63:0]   out_a_q,   out_a_d;
  logic [63:0]   out_b_q,   out_b_d;
  logic          key_wr_q,  key_wr_d;
  logic          data_wr_q, data_wr_d;
  logic          busy_q,    busy_d;
  logic          err_q,     err_d;
  logic          grant_b;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    last_b_d  = last_b_q;
    owner_b_d = owner_b_q;
    key_d     = key_q;
    data_d    = data_q;
    out_a_d   = out_a_q;
    out_b_d   = out_b_q;
    err_d     = err_q;
    busy_d    = busy_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;
    key_wr_d  = 1'b0;
    data_wr_d = 1'b0;
    // On a tie, B wins only when A was the last one served.
    grant_b   = inReqB & (~inReqA | ~last_b_q);

    unique case (state_q)
      ST_IDLE: begin
        if (inReqA || inReqB) begin
          owner_b_d = grant_b;
          key_d     = grant_b ? inKeyB  : inKeyA;
          data_d    = grant_b ? inDataB : inDataA;
          ack_a_d   = ~grant_b;
          ack_b_d   = grant_b;
          key_wr_d  = 1'b1;
          data_wr_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = '0;
        busy_d  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TIMER_ONE;
        // Busy is meaningless in the first WAIT cycle: the core only raises
        // it one cycle after the write strobe.
        if ((timer_q != '0) && !inEncBusy) begin
          if (owner_b_q) begin
            out_b_d   = inEncData;
            valid_b_d = 1'b1;
          end else begin
            out_a_d   = inEncData;
            valid_a_d = 1'b1;
          end
          last_b_d = owner_b_q;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else if (timer_q == TIMER_LAST) begin
          // Aborted job still counts as served so the other side is not starved.
          err_d    = 1'b1;
          last_b_d = owner_b_q;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      key_q     <= '0;
      data_q    <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ack_a_q   <= 1'b0;
      ack_b_q   <= 1'b0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      key_wr_q  <= 1'b0;
      data_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      last_b_q  <= last_b_d;
      owner_b_q <= owner_b_d;
      key_q     <= key_d;
      data_q    <= data_d;
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ack_a_q   <= ack_a_d;
      ack_b_q   <= ack_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      key_wr_q  <= key_wr_d;
      data_wr_q <= data_wr_d;
    end
  end

  assign outAckA       = ack_a_q;
  assign outAckB       = ack_b_q;
  assign outValidA     = valid_a_q;
  assign outValidB     = valid_b_q;
  assign outDataA      = out_a_q;
  assign outDataB      = out_b_q;
  assign outEncKeyWr   = key_wr_q;
  assign outEncDataWr  = data_wr_q;
  assign outEncKeyData = key_q;
  assign outEncData    = data_q;
  assign outBusy       = busy_q;
  assign outErr        = err_q;

endmodule

// File: tb/tb_present_enc_arbiter.sv
// Bench for present_enc_arbiter: a behavioural PRESENT-80 core model answers
// the write strobes, and a small reference model (last-served pointer, held
// ciphertexts, sticky error) predicts every observed result.
module tb_present_enc_arbiter;

  localparam int TIMEOUT = 64;
  localparam int TW      = 7;

  logic        inClk = 1'b0;
  logic        inRstN;
  logic        inReqA, inReqB;
  logic [79:0] inKeyA, inKeyB;
  logic [63:0] inDataA, inDataB;
  logic        outAckA, outValidA, outAckB, outValidB;
  logic [63:0] outDataA, outDataB;
  logic        outEncKeyWr, outEncDataWr;
  logic [79:0] outEncKeyData;
  logic [63:0] outEncData;
  logic [63:0] inEncData;
  logic        inEncBusy;
  logic        outBusy, outErr;

  present_enc_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .inClk(inClk), .inRstN(inRstN),
    .inReqA(inReqA), .inKeyA(inKeyA), .inDataA(inDataA),
    .outAckA(outAckA), .outValidA(outValidA), .outDataA(outDataA),
    .inReqB(inReqB), .inKeyB(inKeyB), .inDataB(inDataB),
    .outAckB(outAckB), .outValidB(outValidB), .outDataB(outDataB),
    .outEncKeyWr(outEncKeyWr), .outEncKeyData(outEncKeyData),
    .outEncDataWr(outEncDataWr), .outEncData(outEncData),
    .inEncData(inEncData), .inEncBusy(inEncBusy),
    .outBusy(outBusy), .outErr(outErr)
  );

  always #5 inClk = ~inClk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- PRESENT-80 reference ----------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
    logic [79:0] k;
    logic [63:0] s, t;
    k = key;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = sbox(s[4*n +: 4]);
      t = '0;
      for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : (b * 16) % 63] = s[b];
      s = t;
      k = {k[18:0], k[79:19]};
      k[79:76] = sbox(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // ---------------- core model ----------------
  int          core_lat = 2;
  int          core_cnt = 0;
  logic        stuck = 1'b0;
  logic [63:0] core_res = '0;

  always @(posedge inClk) begin
    if (outEncKeyWr && outEncDataWr) begin
      core_cnt <= core_lat;
      core_res <= present80(outEncKeyData, outEncData);
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end
  end
  assign inEncBusy = stuck || (core_cnt != 0);
  assign inEncData = core_res;

  // ---------------- monitors ----------------
  int va_cnt = 0, vb_cnt = 0, aa_cnt = 0, ab_cnt = 0;
  int kw_hi = 0, kw_pul = 0, dw_hi = 0, dw_pul = 0;
  logic kw_prev = 1'b0, dw_prev = 1'b0;
  logic [3:0] ev_q[$];

  always @(negedge inClk) begin
    va_cnt  <= va_cnt + (outValidA ? 1 : 0);
    vb_cnt  <= vb_cnt + (outValidB ? 1 : 0);
    aa_cnt  <= aa_cnt + (outAckA ? 1 : 0);
    ab_cnt  <= ab_cnt + (outAckB ? 1 : 0);
    kw_hi   <= kw_hi + (outEncKeyWr ? 1 : 0);
    dw_hi   <= dw_hi + (outEncDataWr ? 1 : 0);
    kw_pul  <= kw_pul + ((outEncKeyWr && !kw_prev) ? 1 : 0);
    dw_pul  <= dw_pul + ((outEncDataWr && !dw_prev) ? 1 : 0);
    kw_prev <= outEncKeyWr;
    dw_prev <= outEncDataWr;
    if (outAckA)   ev_q.push_back(4'h1);
    if (outValidA) ev_q.push_back(4'h2);
    if (outAckB)   ev_q.push_back(4'h3);
    if (outValidB) ev_q.push_back(4'h4);
  end

  // ---------------- reference model state ----------------
  logic        mdl_last_b;
  logic [63:0] mdl_out_a, mdl_out_b;
  logic        mdl_err;

  task automatic mdl_reset();
    mdl_last_b = 1'b1;
    mdl_out_a  = '0;
    mdl_out_b  = '0;
    mdl_err    = 1'b0;
  endtask

  function automatic logic any_out();
    return |{outAckA, outValidA, outDataA, outAckB, outValidB, outDataB,
             outEncKeyWr, outEncKeyData, outEncDataWr, outEncData, outBusy, outErr};
  endfunction

  task automatic cyc();
    @(negedge inClk);
    #1;
  endtask

  task automatic set_req(input bit is_b, input bit v, input logic [79:0] k, input logic [63:0] d);
    if (is_b) begin inReqB = v; inKeyB = k; inDataB = d; end
    else      begin inReqA = v; inKeyA = k; inDataA = d; end
  endtask

  task automatic wait_ack(input bit is_b, input logic [79:0] k, input logic [63:0] d, output int lat);
    int n = 0;
    logic seen;
    do begin cyc(); n++; seen = outAckA | outAckB; end while (!seen && n < 20);
    chk("ack_seen", 128'(seen), 128'(1));
    chk("ack_owner_b", 128'(outAckB), 128'(is_b));
    chk("ack_owner_a", 128'(outAckA), 128'(!is_b));
    chk("issue_strobes", 128'({outEncKeyWr, outEncDataWr}), 128'(2'b11));
    chk("issue_key", 128'(outEncKeyData), 128'(k));
    chk("issue_data", 128'(outEncData), 128'(d));
    chk("issue_busy", 128'(outBusy), 128'(1));
    lat = n;
  endtask

  task automatic finish_job(input bit is_b, input logic [79:0] k, input logic [63:0] d);
    int n = 0;
    logic seen;
    logic [63:0] exp;
    exp = present80(k, d);
    do begin cyc(); n++; seen = is_b ? outValidB : outValidA; end while (!seen && n < 300);
    chk("valid_seen", 128'(seen), 128'(1));
    chk("valid_other", 128'(is_b ? outValidA : outValidB), 128'(0));
    chk("result", 128'(is_b ? outDataB : outDataA), 128'(exp));
    chk("other_held", 128'(is_b ? outDataA : outDataB), 128'(is_b ? mdl_out_a : mdl_out_b));
    chk("err_flag", 128'(outErr), 128'(mdl_err));
    if (is_b) mdl_out_b = exp; else mdl_out_a = exp;
    mdl_last_b = is_b;
  endtask

  task automatic run_job(input bit is_b, input logic [79:0] k, input logic [63:0] d,
                         input int lat, output int ack_lat);
    core_lat = lat;
    set_req(is_b, 1'b1, k, d);
    wait_ack(is_b, k, d, ack_lat);
    set_req(is_b, 1'b0, k, d);
    finish_job(is_b, k, d);
  endtask

  task automatic run_tie(input logic [79:0] ka, input logic [63:0] da,
                         input logic [79:0] kb, input logic [63:0] db, input bit hold);
    bit wb;
    int lat;
    wb = !mdl_last_b;
    core_lat = int'($urandom_range(1, 5));
    set_req(1'b0, 1'b1, ka, da);
    set_req(1'b1, 1'b1, kb, db);
    wait_ack(wb, wb ? kb : ka, wb ? db : da, lat);
    set_req(wb, 1'b0, wb ? kb : ka, wb ? db : da);
    if (!hold) set_req(!wb, 1'b0, wb ? ka : kb, wb ? da : db);
    finish_job(wb, wb ? kb : ka, wb ? db : da);
    if (hold) begin
      wait_ack(!wb, wb ? ka : kb, wb ? da : db, lat);
      set_req(!wb, 1'b0, wb ? ka : kb, wb ? da : db);
      finish_job(!wb, wb ? ka : kb, wb ? da : db);
    end
  endtask

  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int lat;
    int snap_a, snap_b, snap_aa, snap_ab, snap_kh, snap_kp, snap_dh, snap_dp;
    int n;
    logic [79:0] key;
    logic [63:0] pt;
    logic [15:0] seq;

    inRstN = 1'b0;
    inReqA = 1'b0; inKeyA = '0; inDataA = '0;
    inReqB = 1'b0; inKeyB = '0; inDataB = '0;
    mdl_reset();
    cyc();
    chk("reset_outputs", 128'(any_out()), 128'(0));
    cyc();
    inRstN = 1'b1;
    cyc(); cyc();
    chk("idle_outputs", 128'(any_out()), 128'(0));

    // Known-answer job on A
    snap_b = vb_cnt;
    run_job(1'b0, 80'h0, 64'h0, 3, lat);
    chk("ackA_latency", 128'(lat), 128'(1));
    chk("kat_a", 128'(outDataA), 128'(64'h5579C1387B228445));
    chk("no_validB", 128'(vb_cnt - snap_b), 128'(0));

    // Known-answer job on B
    run_job(1'b1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF, 64'h0, 4, lat);
    chk("kat_b", 128'(outDataB), 128'(64'hE72C46C0F5945049));
    chk("kat_a_held", 128'(outDataA), 128'(64'h5579C1387B228445));

    // Simultaneous requests after reset, both held until acked
    inRstN = 1'b0;
    mdl_reset();
    cyc();
    inRstN = 1'b1;
    cyc();
    ev_q.delete();
    run_tie(rnd80(), rnd64(), rnd80(), rnd64(), 1'b1);
    seq = '0;
    foreach (ev_q[i]) if (i < 4) seq[15 - 4*i -: 4] = ev_q[i];
    chk("order_len", 128'(ev_q.size()), 128'(4));
    chk("order_seq", 128'(seq), 128'(16'h1234));

    // Alternation over four tie rounds with random payloads
    for (int r = 0; r < 4; r++) run_tie(rnd80(), rnd64(), rnd80(), rnd64(), 1'b0);

    // Stuck core: timeout on A
    stuck = 1'b1;
    snap_a = va_cnt; snap_b = vb_cnt;
    key = rnd80(); pt = rnd64();
    set_req(1'b0, 1'b1, key, pt);
    wait_ack(1'b0, key, pt, lat);
    set_req(1'b0, 1'b0, key, pt);
    n = 0;
    do begin cyc(); n++; end while (!outErr && n < 200);
    chk("timeout_latency", 128'(n), 128'(TIMEOUT + 1));
    chk("timeout_busy", 128'(outBusy), 128'(0));
    chk("timeout_no_valid", 128'((va_cnt - snap_a) + (vb_cnt - snap_b)), 128'(0));
    chk("timeout_data_held", 128'(outDataA), 128'(mdl_out_a));
    mdl_err = 1'b1;
    mdl_last_b = 1'b0;
    stuck = 1'b0;
    // Tie after the aborted A job must go to B; error stays set
    run_tie(rnd80(), rnd64(), rnd80(), rnd64(), 1'b0);
    chk("err_sticky", 128'(outErr), 128'(1));

    // Reset in the middle of WAIT
    key = rnd80(); pt = rnd64();
    core_lat = 30;
    set_req(1'b0, 1'b1, key, pt);
    wait_ack(1'b0, key, pt, lat);
    set_req(1'b0, 1'b0, key, pt);
    cyc(); cyc(); cyc();
    inRstN = 1'b0;
    #1;
    chk("midreset_outputs", 128'(any_out()), 128'(0));
    mdl_reset();
    cyc(); cyc();
    inRstN = 1'b1;
    snap_a = va_cnt; snap_b = vb_cnt; snap_aa = aa_cnt; snap_ab = ab_cnt;
    for (int i = 0; i < 40; i++) cyc();
    chk("post_reset_quiet",
        128'((va_cnt - snap_a) + (vb_cnt - snap_b) + (aa_cnt - snap_aa) + (ab_cnt - snap_ab)),
        128'(0));
    chk("post_reset_outputs", 128'(any_out()), 128'(0));
    run_job(1'b0, rnd80(), rnd64(), 2, lat);

    // Ten chained jobs: key ^= index, plaintext = previous ciphertext
    snap_kh = kw_hi; snap_kp = kw_pul; snap_dh = dw_hi; snap_dp = dw_pul;
    key = rnd80(); pt = rnd64();
    for (int i = 1; i <= 10; i++) begin
      key = key ^ 80'(i);
      run_job(i[0], key, pt, int'($urandom_range(1, 6)), lat);
      pt = present80(key, pt);
    end
    cyc();
    chk("keywr_pulses", 128'(kw_pul - snap_kp), 128'(10));
    chk("keywr_cycles", 128'(kw_hi - snap_kh), 128'(10));
    chk("datawr_pulses", 128'(dw_pul - snap_dp), 128'(10));
    chk("datawr_cycles", 128'(dw_hi - snap_dh), 128'(10));
    chk("chain_last", 128'(outDataA), 128'(pt));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
